// File: rtl/nanjing_cpu_regs.sv
// nanjing_cpu_regs: CPU-side register front end for the nanjing mapper.
//
// Decodes CPU writes to $5xxx, stages the low PRG nibble from $50xx and
// commits it together with the high field from $52xx. It also holds the
// $53xx mode latch and an optional protection register with read-back.
//
// All state updates happen on the FALLING edge of m2 (end of CPU cycle).
//
// Build option:
//   NANJING_PROT_READ_EN  defined   -> $51xx protection register, TRIG flip
//                                      logic and $51xx/$55xx read-back.
//                         undefined -> no protection logic; cpu_dout = 0,
//                                      cpu_doe = 0, $51xx writes ignored.
//
// Ports:
//   m2         in   clock (falling-edge active)
//   rst_n      in   asynchronous active-low reset
//   cpu_rw     in   1 = read, 0 = write
//   cpu_addr   in   {~romsel_n, A14..A0}
//   cpu_din    in   CPU data bus input
//   cpu_dout   out  protection read-back data
//   cpu_doe    out  1 = drive cpu_dout onto the bus
//   prg_bank   out  committed PRG bank {hi, lo}
//   mode       out  $53xx[1:0]
//   chr_split  out  $53xx[7], auto CHR split enable
//   pending    out  1 = low nibble staged, awaiting $52xx
module nanjing_cpu_regs #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned PRG_HI_W = 2
) (
  input  logic                  m2,
  input  logic                  rst_n,
  input  logic                  cpu_rw,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_doe,
  output logic [4+PRG_HI_W-1:0] prg_bank,
  output logic [1:0]            mode,
  output logic                  chr_split,
  output logic                  pending
);

  localparam int unsigned BankW   = 4 + PRG_HI_W;
  localparam logic [7:0]  CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic [1:0]         mode_q, mode_d;
  logic               split_q, split_d;

  logic [7:0] page;
  logic       wr;
  logic       wr_lo, wr_hi, wr_mode;

  assign page    = cpu_addr[15:8];
  assign wr      = ~cpu_rw;
  assign wr_lo   = wr & (page == 8'h50);
  assign wr_hi   = wr & (page == 8'h52);
  assign wr_mode = wr & (page == 8'h53);

  // Bus bits that only some build options consume.
  logic unused_bus;
  assign unused_bus = ^{cpu_din, cpu_addr};

  // Bank staging FSM plus the independent mode latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bank_d   = bank_q;
    mode_d   = mode_q;
    split_d  = split_q;

    unique case (state_q)
      StIdle: begin
        if (wr_lo) begin
          shadow_d = cpu_din[3:0];
          cnt_d    = 8'd0;
          state_d  = StPend;
        end else if (wr_hi) begin
          // Nothing staged: only the high field moves.
          bank_d = {cpu_din[PRG_HI_W-1:0], bank_q[3:0]};
        end
      end
      StPend: begin
        if (wr_lo) begin
          shadow_d = cpu_din[3:0];
          cnt_d    = 8'd0;
        end else if (wr_hi) begin
          // Atomic commit of both halves.
          bank_d   = {cpu_din[PRG_HI_W-1:0], shadow_q};
          shadow_d = 4'd0;
          cnt_d    = 8'd0;
          state_d  = StIdle;
        end else if (cnt_q == CntLast) begin
          // High half never arrived: drop the staged nibble.
          shadow_d = 4'd0;
          cnt_d    = 8'd0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_mode) begin
      mode_d  = cpu_din[1:0];
      split_d = cpu_din[7];
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      shadow_q <= 4'd0;
      bank_q   <= '0;
      mode_q   <= 2'd0;
      split_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
      mode_q   <= mode_d;
      split_q  <= split_d;
    end
  end

  assign prg_bank  = bank_q;
  assign mode      = mode_q;
  assign chr_split = split_q;
  assign pending   = (state_q == StPend);

`ifdef NANJING_PROT_READ_EN
  logic [7:0] sec_q, sec_d;
  logic       flip_q, flip_d;
  logic       trig_last_q, trig_last_d;
  logic       wr_sec, wr_trig;

  assign wr_sec  = wr & (page == 8'h51) & ~cpu_addr[0];
  assign wr_trig = wr & (page == 8'h51) &  cpu_addr[0];

  always_comb begin
    sec_d       = sec_q;
    flip_d      = flip_q;
    trig_last_d = trig_last_q;
    if (wr_sec) begin
      sec_d = cpu_din;
    end
    if (wr_trig) begin
      // A 1 -> 0 transition on the trigger bit toggles the read-back flip.
      if (trig_last_q && !cpu_din[0]) begin
        flip_d = ~flip_q;
      end
      trig_last_d = cpu_din[0];
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= 8'd0;
      flip_q      <= 1'b0;
      trig_last_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      flip_q      <= flip_d;
      trig_last_q <= trig_last_d;
    end
  end

  assign cpu_dout = {sec_q[7:1], sec_q[0] ^ flip_q};
  // Qualified by rst_n so the bus is never driven while in reset.
  assign cpu_doe  = m2 & rst_n & cpu_rw & ((page == 8'h51) | (page == 8'h55));
`else
  assign cpu_dout = 8'h00;
  assign cpu_doe  = 1'b0;
`endif

endmodule

// File: tb/tb_nanjing_cpu_regs.sv
module tb_nanjing_cpu_regs;

  localparam int unsigned TO = 255;
  localparam int unsigned HW = 2;
  localparam int unsigned BW = 4 + HW;
`ifdef NANJING_PROT_READ_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          m2 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_rw = 1'b1;
  logic [15:0]   cpu_addr = 16'h0000;
  logic [7:0]    cpu_din = 8'h00;
  logic [7:0]    cpu_dout;
  logic          cpu_doe;
  logic [BW-1:0] prg_bank;
  logic [1:0]    mode;
  logic          chr_split;
  logic          pending;

  nanjing_cpu_regs #(
    .TIMEOUT (TO),
    .PRG_HI_W(HW)
  ) dut (
    .m2       (m2),
    .rst_n    (rst_n),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_doe  (cpu_doe),
    .prg_bank (prg_bank),
    .mode     (mode),
    .chr_split(chr_split),
    .pending  (pending)
  );

  always #5 m2 = ~m2;

  int total = 0;
  int bad   = 0;

  // Reference model: a staged nibble carries an absolute expiry edge number.
  logic [BW-1:0] m_bank;
  logic [1:0]    m_mode;
  logic          m_split;
  logic          m_pend;
  logic [3:0]    m_shadow;
  longint        edge_n;
  longint        m_deadline;
  logic [7:0]    m_sec;
  logic          m_flip;
  logic          m_tlast;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank   = '0;
    m_mode   = 2'd0;
    m_split  = 1'b0;
    m_pend   = 1'b0;
    m_shadow = 4'd0;
    m_sec    = 8'd0;
    m_flip   = 1'b0;
    m_tlast  = 1'b0;
  endtask

  function automatic logic [7:0] dout_exp();
    return PROT ? {m_sec[7:1], m_sec[0] ^ m_flip} : 8'h00;
  endfunction

  function automatic logic doe_exp(input logic rw, input logic [15:0] addr);
    return PROT && rw && (addr[15:8] == 8'h51 || addr[15:8] == 8'h55);
  endfunction

  task automatic model_edge(input logic rw, input logic [15:0] addr, input logic [7:0] din);
    logic [7:0] pg;
    pg = addr[15:8];
    edge_n++;
    if (!rw && pg == 8'h50) begin
      m_shadow   = din[3:0];
      m_pend     = 1'b1;
      m_deadline = edge_n + longint'(TO);
    end else if (!rw && pg == 8'h52) begin
      m_bank = m_pend ? {din[HW-1:0], m_shadow} : {din[HW-1:0], m_bank[3:0]};
      m_pend = 1'b0;
    end else if (m_pend && edge_n == m_deadline) begin
      m_pend = 1'b0;
    end
    if (!rw && pg == 8'h53) begin
      m_mode  = din[1:0];
      m_split = din[7];
    end
    if (PROT && !rw && pg == 8'h51) begin
      if (!addr[0]) begin
        m_sec = din;
      end else begin
        if (m_tlast && !din[0]) m_flip = ~m_flip;
        m_tlast = din[0];
      end
    end
  endtask

  task automatic check_state(input string tag);
    check8({tag, "/bank"}, 8'(prg_bank), 8'(m_bank));
    check8({tag, "/mode"}, 8'(mode), 8'(m_mode));
    check8({tag, "/split"}, 8'(chr_split), 8'(m_split));
    check8({tag, "/pend"}, 8'(pending), 8'(m_pend));
    check8({tag, "/dout"}, cpu_dout, dout_exp());
  endtask

  // One CPU cycle, entered and left just after a falling edge of m2.
  task automatic cyc(input logic rw, input logic [15:0] addr, input logic [7:0] din,
                     input string tag);
    cpu_rw   = rw;
    cpu_addr = addr;
    cpu_din  = din;
    @(posedge m2);
    #1;
    check8({tag, "/doe_hi"}, 8'(cpu_doe), 8'(doe_exp(rw, addr)));
    @(negedge m2);
    model_edge(rw, addr, din);
    #1;
    check8({tag, "/doe_lo"}, 8'(cpu_doe), 8'h00);
    check_state(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 16'h8000, 8'h00, tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pages [8];
    logic [7:0] pg;
    pages = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h55, 8'h54, 8'h45, 8'hD0};
    edge_n     = 0;
    m_deadline = 0;
    model_reset();

    // Reset held: outputs at reset values, no bus drive even on a read.
    cpu_rw   = 1'b1;
    cpu_addr = 16'h5500;
    @(posedge m2);
    #1;
    check8("rst/doe", 8'(cpu_doe), 8'h00);
    check_state("rst");
    @(negedge m2);
    #1;
    rst_n = 1'b1;

    idle(10, "idle10");
    check8("idle10/bank0", 8'(prg_bank), 8'h00);

    // Staged low then high commit.
    cyc(1'b0, 16'h5000, 8'h0A, "lo_0a");
    check8("lo_0a/pending1", 8'(pending), 8'h01);
    cyc(1'b0, 16'h5200, 8'h03, "hi_03");
    check8("hi_03/bank3a", 8'(prg_bank), 8'h3A);
    check8("hi_03/pending0", 8'(pending), 8'h00);

    // Timeout: pending drops exactly TO idle edges after the low write.
    cyc(1'b0, 16'h5000, 8'h05, "lo_05");
    idle(TO - 1, "to_wait");
    check8("to/still_pend", 8'(pending), 8'h01);
    idle(1, "to_edge");
    check8("to/dropped", 8'(pending), 8'h00);
    check8("to/bank_kept", 8'(prg_bank), 8'h3A);

    // Last low write wins.
    cyc(1'b0, 16'h5000, 8'h07, "lo_07");
    cyc(1'b0, 16'h5000, 8'h09, "lo_09");
    cyc(1'b0, 16'h5200, 8'h01, "hi_01");
    check8("last_low/bank19", 8'(prg_bank), 8'h19);

    // Mode latch.
    cyc(1'b0, 16'h5300, 8'h83, "mode_83");
    check8("mode/val", 8'(mode), 8'h03);
    check8("mode/split", 8'(chr_split), 8'h01);

    // Protection register and trigger flip.
    cyc(1'b0, 16'h5100, 8'h55, "sec_55");
    cyc(1'b0, 16'h5101, 8'h01, "trig_1");
    cyc(1'b0, 16'h5101, 8'h00, "trig_0");
    cyc(1'b1, 16'h5500, 8'h00, "rd_55");
    check8("prot/dout", cpu_dout, PROT ? 8'h54 : 8'h00);
    cyc(1'b1, 16'h5100, 8'h00, "rd_51");
    cyc(1'b1, 16'h5400, 8'h00, "rd_54");

    // Reset in the middle of a pending stage.
    cyc(1'b0, 16'h5000, 8'h0F, "lo_0f");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check8("midrst/pending0", 8'(pending), 8'h00);
    check_state("midrst");
    @(negedge m2);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 16'h5200, 8'h02, "hi_02");
    check8("midrst/bank20", 8'(prg_bank), 8'h20);

    // Random traffic with occasional long idle stretches around the timeout.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        idle(int'($urandom_range(TO - 3, TO + 3)), "rnd_idle");
      end else begin
        pg = pages[$urandom_range(0, 7)];
        cyc(1'($urandom_range(0, 1)), {pg, 8'($urandom)}, 8'($urandom), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
